reconfig_operand_recover: RTL

RECONFIG_OPERAND_RECOVER -- requirements
Module: reconfig_operand_recover

---
 rtl/reconfig_operand_recover_if.sv | 27 ++
 rtl/reconfig_operand_recover.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/reconfig_operand_recover_if.sv
// Request/result handshake bundle for reconfig_operand_recover.
// The master drives requests and the result ready; the slave returns the recovered result.
interface reconfig_operand_recover_if;
  localparam int unsigned YW = 9;
  localparam int unsigned AW = 8;

  logic          in_valid;
  logic          in_ready;
  logic [YW-1:0] y;
  logic [AW-1:0] b;
  logic          s0;
  logic          s1;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] a_out;
  logic          err;

  modport master (
    output in_valid, y, b, s0, s1, out_ready,
    input  in_ready, out_valid, a_out, err
  );

  modport slave (
    input  in_valid, y, b, s0, s1, out_ready,
    output in_ready, out_valid, a_out, err
  );
endinterface

// File: rtl/reconfig_operand_recover.sv
// Recovers operand a = y - b with a bit-serial, LSB-first subtractor and
// optionally writes the in-range result into one of three operand registers.
module reconfig_operand_recover (
  input  logic                          clk,
  input  logic                          rst,
  reconfig_operand_recover_if.slave     bus,
  output logic [7:0]                    a1_q,
  output logic [7:0]                    a2_q,
  output logic [7:0]                    a3_q,
  output logic                          busy
);
  localparam int unsigned YW = 9;
  localparam int unsigned AW = 8;
  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] LAST_BIT = CW'(YW - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [YW-1:0] y_q;
  logic [YW-1:0] b_q;
  logic [1:0]    mode_q;
  logic          br_q;
  logic [CW-1:0] cnt_q;
  logic [YW-1:0] diff_q;
  logic          out_valid_q;
  logic          in_ready_q;
  logic [AW-1:0] a_out_q;
  logic          err_q;

  logic          accept_c;
  logic          last_c;
  logic          release_c;
  logic          d_c;
  logic          br_c;
  logic [YW-1:0] diff_c;
  logic          err_c;

  // One full-subtractor bit per CALC edge; operand registers shift right so bit 0 is current.
  assign d_c    = y_q[0] ^ b_q[0] ^ br_q;
  assign br_c   = (~y_q[0] & b_q[0]) | (~(y_q[0] ^ b_q[0]) & br_q);
  assign diff_c = diff_q | (YW'(d_c) << cnt_q);
  assign err_c  = diff_c[YW-1] | br_c;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    accept_c  = 1'b0;
    last_c    = 1'b0;
    release_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          accept_c = 1'b1;
          state_d  = CALC;
        end
      end
      CALC: begin
        if (cnt_q == LAST_BIT) begin
          last_c  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          release_c = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath, result and destination registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      y_q         <= '0;
      b_q         <= '0;
      mode_q      <= '0;
      br_q        <= 1'b0;
      cnt_q       <= '0;
      diff_q      <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy        <= 1'b0;
      a_out_q     <= '0;
      err_q       <= 1'b0;
      a1_q        <= '0;
      a2_q        <= '0;
      a3_q        <= '0;
    end else begin
      in_ready_q <= (state_d == IDLE);
      busy       <= (state_d != IDLE);
      if (accept_c) begin
        y_q    <= bus.y;
        b_q    <= {1'b0, bus.b};
        mode_q <= {bus.s0, bus.s1};
        br_q   <= 1'b0;
        cnt_q  <= '0;
        diff_q <= '0;
      end
      if (state_q == CALC) begin
        y_q    <= y_q >> 1;
        b_q    <= b_q >> 1;
        br_q   <= br_c;
        diff_q <= diff_c;
        cnt_q  <= cnt_q + CW'(1);
      end
      if (last_c) begin
        a_out_q     <= diff_c[AW-1:0];
        err_q       <= err_c;
        out_valid_q <= 1'b1;
        if (!err_c) begin
          case (mode_q)
            2'b00:   a1_q <= diff_c[AW-1:0];
            2'b01:   a2_q <= diff_c[AW-1:0];
            2'b10:   a3_q <= diff_c[AW-1:0];
            default: ;
          endcase
        end
      end
      if (release_c) out_valid_q <= 1'b0;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.a_out     = a_out_q;
  assign bus.err       = err_q;

endmodule
